// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if: AHB-Lite bus signals between a master and the SRAM slave.
// Master drives HSEL/HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA; HREADY is the
// selected slave's HREADYOUT; the slave returns HRDATA/HREADYOUT/HRESP.
interface ahb_lite_sram_slave_if #(parameter int DATA_W = 32);
    logic              HSEL;
    logic [31:0]       HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [1:0]        HTRANS;
    logic              HREADY;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    modport master (output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
                    input HRDATA, HREADYOUT, HRESP);
    modport slave (input HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
                   output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite slave over a 2^ADDR_W-word SRAM with WAIT_STATES wait cycles and 2-cycle ERROR.
// Ports: HCLK bus clock, HRESETn async active-low reset, bus = AHB-Lite slave modport.
module ahb_lite_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_lite_sram_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;
    state_e            state_q, state_d, start_st;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_idx;
    logic              write_q, write_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              take, addr_err, fwd;
    logic              unused;
    assign unused = ^{bus.HBURST, bus.HTRANS[0]};
    // A new address phase can only land while this slave is not stalling the bus.
    assign take     = bus.HSEL && bus.HREADY && bus.HTRANS[1] && (state_q inside {IDLE, DATA, ERR2});
    assign addr_err = (bus.HADDR[31:ADDR_W] != '0) || (bus.HSIZE != 3'b010);
    assign start_st = addr_err ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
    // Read index: the latched address after wait states, else the address phase on the bus.
    assign rd_idx   = (state_q == WAIT) ? addr_q : bus.HADDR[ADDR_W-1:0];
    // A read overlapping the final data cycle of a write to the same word sees the new data.
    assign fwd      = (state_q == DATA) && write_q && (addr_q == rd_idx);
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE, DATA, ERR2: state_d = take ? start_st : IDLE;
            WAIT: begin
                state_d = (int'(cnt_q) == WAIT_STATES - 1) ? DATA : WAIT;
                cnt_d   = (int'(cnt_q) == WAIT_STATES - 1) ? 2'd0 : cnt_q + 2'd1;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        addr_d   = take ? bus.HADDR[ADDR_W-1:0] : addr_q;
        write_d  = take ? (bus.HWRITE && !addr_err) : write_q;
        hrdata_d = (state_d == DATA) ? (fwd ? bus.HWDATA : mem[rd_idx]) : hrdata_q;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            hrdata_q <= hrdata_d;
        end
    end
    always_ff @(posedge HCLK) begin
        if (state_q == DATA && write_q)
            mem[addr_q] <= bus.HWDATA;
    end
    assign bus.HREADYOUT = !(state_q == WAIT || state_q == ERR1);
    assign bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
    assign bus.HRDATA    = hrdata_q;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: two slaves (W=0 and W=2) on one master, checked against a transfer-level model.
module tb_ahb_lite_sram_slave;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        first;
        logic        incr4;
    } xfer_t;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;
    ahb_lite_sram_slave_if #(.DATA_W(32)) bus0();
    ahb_lite_sram_slave_if #(.DATA_W(32)) bus2();
    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0.slave));
    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(2)) dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2.slave));
    logic        sel = 1'b0;
    logic        m_sel = 1'b0, m_write = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [2:0]  m_size = 3'b010, m_burst = '0;
    logic [1:0]  m_trans = '0;
    wire         hready = sel ? bus2.HREADYOUT : bus0.HREADYOUT;
    wire         hresp  = sel ? bus2.HRESP : bus0.HRESP;
    wire  [31:0] rdata  = sel ? bus2.HRDATA : bus0.HRDATA;
    assign bus0.HSEL = m_sel & ~sel;
    assign bus2.HSEL = m_sel & sel;
    assign bus0.HADDR = m_addr;   assign bus2.HADDR = m_addr;
    assign bus0.HWRITE = m_write; assign bus2.HWRITE = m_write;
    assign bus0.HSIZE = m_size;   assign bus2.HSIZE = m_size;
    assign bus0.HBURST = m_burst; assign bus2.HBURST = m_burst;
    assign bus0.HTRANS = m_trans; assign bus2.HTRANS = m_trans;
    assign bus0.HWDATA = m_wdata; assign bus2.HWDATA = m_wdata;
    assign bus0.HREADY = hready;  assign bus2.HREADY = hready;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] mem_m [2][256];
    bit          vld [2][256];
    xfer_t       xq [$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    function automatic bit is_err(input xfer_t t);
        return (t.addr[31:8] != 24'd0) || (t.size != 3'b010);
    endfunction
    task automatic push(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data, input logic first, input logic incr4);
        xfer_t t;
        t.wr = wr; t.addr = addr; t.size = size; t.data = data; t.first = first; t.incr4 = incr4;
        xq.push_back(t);
    endtask
    task automatic burst4(input logic wr, input logic [31:0] base, input logic [31:0] d0, input bit rnd);
        for (int i = 0; i < 4; i++)
            push(wr, base + 32'(i), 3'b010, rnd ? $urandom : d0 + 32'(i), i == 0, 1'b1);
    endtask
    task automatic set_ap(input logic wr, input logic [31:0] a, input logic [1:0] tr, input logic [2:0] bu);
        m_sel = 1'b1; m_write = wr; m_addr = a; m_size = 3'b010; m_trans = tr; m_burst = bu;
    endtask
    task automatic set_idle();
        if ($urandom_range(0, 1) == 0) begin
            m_sel = 1'b0; m_trans = 2'($urandom);
        end else begin
            m_sel = 1'b1; m_trans = {1'b0, 1'($urandom)};
        end
        m_addr = $urandom; m_write = 1'($urandom); m_size = 3'($urandom);
    endtask
    // Runs the queued transfers on the selected slave; called and returning at a negedge.
    task automatic run_seq(input bit gaps);
        xfer_t dp;
        bit    dp_v, err, rdy, drv;
        int    k, w;
        dp_v = 0; k = 0; w = sel ? 2 : 0;
        while (xq.size() > 0 || dp_v) begin
            err = dp_v && is_err(dp);
            rdy = !dp_v || (err ? (k == 1) : (k == w));
            check("hreadyout", 32'(hready), 32'(rdy));
            check("hresp", 32'(hresp), 32'(err));
            if (dp_v && rdy && !err && !dp.wr && vld[sel][dp.addr[7:0]])
                check("hrdata", rdata, mem_m[sel][dp.addr[7:0]]);
            m_wdata = (dp_v && dp.wr) ? dp.data : $urandom;
            drv = xq.size() > 0 && !err && !(gaps && xq[0].first && $urandom_range(0, 3) == 0);
            if (drv)
                set_ap(xq[0].wr, xq[0].addr, xq[0].first ? 2'b10 : 2'b11, xq[0].incr4 ? 3'b011 : 3'b000);
            else
                set_idle();
            m_size = drv ? xq[0].size : m_size;
            @(posedge HCLK);
            if (dp_v && rdy) begin
                if (!err && dp.wr) begin
                    mem_m[sel][dp.addr[7:0]] = dp.data;
                    vld[sel][dp.addr[7:0]] = 1'b1;
                end
                dp_v = 0;
            end else if (dp_v)
                k++;
            if (drv && rdy) begin
                dp = xq.pop_front();
                dp_v = 1;
                k = 0;
            end
            @(negedge HCLK);
        end
        m_sel = 1'b0; m_trans = 2'b00;
    endtask
    task automatic rand_seq(input int n);
        for (int a = 0; a < 16; a++)
            push(1'b1, 32'(a), 3'b010, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                burst4(1'($urandom), 32'($urandom_range(0, 12)), 32'd0, 1'b1);
            else
                push(1'($urandom),
                     ($urandom_range(0, 9) == 0) ? (32'h100 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 15)),
                     ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010, $urandom, 1'b1, 1'b0);
        end
        run_seq(1'b1);
    endtask
    initial begin
        #1;
        check("rst_hreadyout0", 32'(bus0.HREADYOUT), 32'd1);
        check("rst_hresp0", 32'(bus0.HRESP), 32'd0);
        check("rst_hrdata0", bus0.HRDATA, 32'd0);
        check("rst_hreadyout2", 32'(bus2.HREADYOUT), 32'd1);
        check("rst_hrdata2", bus2.HRDATA, 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        sel = 1'b0;
        push(1'b1, 32'h05, 3'b010, 32'hDEADBEEF, 1'b1, 1'b0);
        push(1'b0, 32'h05, 3'b010, 32'h0, 1'b1, 1'b0);
        push(1'b1, 32'h20, 3'b010, 32'h11111111, 1'b1, 1'b0);
        push(1'b0, 32'h20, 3'b010, 32'h0, 1'b1, 1'b0);
        burst4(1'b1, 32'h10, 32'hA0, 1'b0);
        burst4(1'b0, 32'h10, 32'h0, 1'b0);
        run_seq(1'b0);
        push(1'b1, 32'h00, 3'b010, 32'h5A5A5A5A, 1'b1, 1'b0);
        push(1'b1, 32'h100, 3'b010, 32'hBAD0BAD0, 1'b1, 1'b0);
        push(1'b1, 32'h00, 3'b000, 32'hBAD1BAD1, 1'b1, 1'b0);
        push(1'b0, 32'h00, 3'b010, 32'h0, 1'b1, 1'b0);
        run_seq(1'b0);
        sel = 1'b1;
        push(1'b1, 32'h07, 3'b010, 32'h07070707, 1'b1, 1'b0);
        push(1'b0, 32'h07, 3'b010, 32'h0, 1'b1, 1'b0);
        push(1'b1, 32'h100, 3'b010, 32'hBAD2BAD2, 1'b1, 1'b0);
        push(1'b0, 32'h07, 3'b010, 32'h0, 1'b1, 1'b0);
        burst4(1'b1, 32'h40, 32'hB0, 1'b0);
        burst4(1'b0, 32'h40, 32'h0, 1'b0);
        run_seq(1'b0);
        sel = 1'b0;
        push(1'b1, 32'h30, 3'b010, 32'h30303030, 1'b1, 1'b0);
        push(1'b1, 32'h31, 3'b010, 32'h31313131, 1'b1, 1'b0);
        push(1'b1, 32'h32, 3'b010, 32'h32323232, 1'b1, 1'b0);
        run_seq(1'b0);
        set_ap(1'b1, 32'h30, 2'b10, 3'b011);
        @(posedge HCLK);
        @(negedge HCLK);
        m_wdata = 32'hC0DE0000;
        set_ap(1'b1, 32'h31, 2'b11, 3'b011);
        @(posedge HCLK);
        @(negedge HCLK);
        m_wdata = 32'hC0DE0001;
        set_ap(1'b1, 32'h32, 2'b11, 3'b011);
        #2 HRESETn = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        check("midrst_hresp", 32'(bus0.HRESP), 32'd0);
        check("midrst_hrdata0", bus0.HRDATA, 32'd0);
        check("midrst_hrdata2", bus2.HRDATA, 32'd0);
        mem_m[0][8'h30] = 32'hC0DE0000;
        @(negedge HCLK);
        m_sel = 1'b0; m_trans = 2'b00;
        HRESETn = 1'b1;
        push(1'b0, 32'h31, 3'b010, 32'h0, 1'b1, 1'b0);
        push(1'b0, 32'h30, 3'b010, 32'h0, 1'b1, 1'b0);
        push(1'b0, 32'h32, 3'b010, 32'h0, 1'b1, 1'b0);
        run_seq(1'b0);
        rand_seq(80);
        sel = 1'b1;
        rand_seq(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL timeout: got no end of test, expected finish before 500000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite slave holding a word-addressed, single-port SRAM. It is the responder for the team's AHB-Lite master BFM: it accepts single and INCR4 read/write transfers, inserts a configurable number of wait states, and signals ERROR on illegal accesses. It sits behind the `Slave` modport of the AHB interface as the DUT on the emulation platform.

## Interface
- DATA_W, 32, data bus width
- ADDR_W, 8, word-index width; depth = 2^ADDR_W words
- WAIT_STATES, 0, wait cycles per data phase, 0..3
- HCLK  input  1  bus clock; all state on rising edge
- HRESETn  input  1  reset, asynchronous, active-low
- HSEL  input  1  slave select
- HADDR  input  32  word index (master increments by 1 per beat)
- HWRITE  input  1  1 = write, 0 = read
- HSIZE  input  3  transfer size; only 3'b010 is legal
- HBURST  input  3  burst type; SINGLE and INCR4 are supported, others treated as INCR
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HREADY  input  1  bus ready (HREADYOUT of selected slave)
- HWDATA  input  DATA_W  write data, valid in data phase
- HRDATA  output  DATA_W  read data
- HREADYOUT  output  1  1 = data phase completes this cycle
- HRESP  output  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase accepted on a rising edge when HSEL & HREADY & HTRANS[1]; latch addr, write flag, and error flag.
- Error flag set if HADDR[31:ADDR_W] != 0 or HSIZE != 3'b010.
- IDLE/BUSY, or HSEL low: no access; next data phase is zero-wait OKAY.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: on accepted transfer -> ERR1 if error, else WAIT if WAIT_STATES>0, else DATA.
- WAIT: HREADYOUT=0, HRESP=0; wait counter counts up; -> DATA when count == WAIT_STATES-1.
- DATA: HREADYOUT=1, HRESP=0. A write commits mem[addr] <= HWDATA on the edge ending DATA. A read drives mem[addr] on HRDATA. A new address phase accepted on the same edge -> restart per IDLE rules; otherwise -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1; -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1; memory untouched. A new address phase is accepted only if the master drives it; after ERROR the master drives IDLE. -> IDLE, or restart.
- HRDATA is registered. It loads mem[addr] on the edge entering DATA, so it is valid throughout DATA. It holds its value otherwise. It is never X after reset.
- Read-after-write hazard: a read address phase overlapping the data phase of a write to the same index forwards HWDATA into HRDATA instead of stale memory.
- INCR4: each beat is an independent address phase. The slave does not generate addresses; it follows HADDR.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending write dropped.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously), and an uncommitted write is lost.
- Zero-wait read latency: address at edge N, HRDATA valid in cycle N to N+1, sampled by the master at edge N+1.
- With WAIT_STATES=W: each data phase lasts W+1 cycles, HREADYOUT is low for the first W, and write data is sampled on the last edge.
- INCR4 at W=0: four beats complete on four consecutive edges after the first address phase, with no bubbles.
- ERROR is always exactly 2 cycles, regardless of WAIT_STATES.
- Back-to-back transfers: address phase of transfer k+1 coincides with the final data cycle of transfer k.

## Test plan
- W=0: write 0xDEADBEEF to 0x05, then read 0x05 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HRESP=0, HREADYOUT never low.
- W=0: write 0x11111111 to 0x20 immediately followed by a read of 0x20 (pipelined) -> read returns 0x11111111 via forwarding.
- INCR4 write 0xA0..0xA3 to 0x10..0x13, then INCR4 read from 0x10 -> four consecutive beats 0xA0,0xA1,0xA2,0xA3 with HREADYOUT=1 throughout.
- W=2: single read of 0x07 -> HREADYOUT 0,0,1 over the data phase; data valid only in the third cycle.
- Write to HADDR=0x100 (ADDR_W=8) or with HSIZE=3'b000 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; a later read of index 0x00 shows it unchanged.
- Assert HRESETn low during beat 2 of an INCR4 write -> outputs reset within the cycle, beat 2 not written, and the next single read completes zero-wait OKAY.
